// File: rtl/mc_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mc_mem_responder
// Purpose  : Unified instruction/data memory for the multicycle RISC-V core.
//            Accepts one read or write request at a time, completes it after
//            LATENCY edges (counting the acceptance edge), and signals
//            completion with a single-cycle ready pulse.
// Ports    : clk, reset (sync, active-high)
//            mem_read, mem_write, addr, wdata   - request from the core
//            rdata, ready, busy, err            - response to the core
// Options  : `define MC_MEM_MISALIGN_TRAP_EN to suppress misaligned accesses
//            (addr[1:0] != 0) and flag them on err together with ready.
//            Without it, err is tied low and addr[1:0] is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mc_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(LATENCY - 1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_WAIT = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic             r_write;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             w_req;
    logic             w_enter_done;
    logic [IDX_W-1:0] w_c_idx;
    logic [31:0]      w_c_wdata;
    logic             w_c_write;
    logic             w_c_fault;
    logic             w_unused_addr;

    assign w_req = mem_read | mem_write;

    // With LATENCY=1 the commit happens on the acceptance edge itself, so the
    // latched copies are not yet valid and the live request must be used.
    assign w_enter_done = (LATENCY == 1) ? ((r_state == C_IDLE) && w_req)
                                         : ((r_state == C_WAIT) && (r_cnt == CNT_W'(1)));
    assign w_c_idx   = (LATENCY == 1) ? addr[IDX_W+1:2] : r_idx;
    assign w_c_wdata = (LATENCY == 1) ? wdata           : r_wdata;
    assign w_c_write = (LATENCY == 1) ? mem_write       : r_write;

    // Upper address bits alias (address wraps modulo DEPTH_WORDS*4).
    assign w_unused_addr = ^{addr[ADDR_W-1:IDX_W+2], addr[1:0]};

`ifdef MC_MEM_MISALIGN_TRAP_EN
    logic r_fault;

    assign w_c_fault = (LATENCY == 1) ? (addr[1:0] != 2'b00) : r_fault;
    // r_fault is captured on acceptance for every LATENCY, so it is valid in DONE.
    assign err       = (r_state == C_DONE) && r_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if ((r_state == C_IDLE) && w_req) begin
            r_fault <= (addr[1:0] != 2'b00);
        end
    end
`else
    assign w_c_fault = 1'b0;
    assign err       = 1'b0;
`endif

    assign ready = (r_state == C_DONE);
    assign busy  = (r_state != C_IDLE);

    // Control FSM and read-data register. A reset in WAIT simply returns to
    // IDLE, so an uncommitted operation is dropped without a ready pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            rdata   <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_req) begin
                        r_idx   <= addr[IDX_W+1:2];
                        r_wdata <= wdata;
                        r_write <= mem_write;  // write wins over a simultaneous read
                        r_cnt   <= C_CNT_LOAD;
                        r_state <= (LATENCY == 1) ? C_DONE : C_WAIT;
                    end
                end
                C_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= C_DONE;
                    end
                end
                C_DONE: begin
                    r_state <= C_IDLE;
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase

            if (w_enter_done && !w_c_write && !w_c_fault) begin
                rdata <= r_mem[w_c_idx];
            end
        end
    end

    // Storage is intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && w_enter_done && w_c_write && !w_c_fault) begin
            r_mem[w_c_idx] <= w_c_wdata;
        end
    end

endmodule
`default_nettype wire
